// File: rtl/mmio_button_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_button_ctrl
//
// Memory-mapped button/LED block that sits between the processor data-memory
// port and RAM. Accesses inside the register window are served locally; all
// other accesses pass straight through to RAM.
//
// Register map (word addresses):
//    BASE_ADDR+0  STATUS  RO   debounced button levels
//    BASE_ADDR+1  EDGE    W1C  sticky rising-edge flags
//    BASE_ADDR+2  OUT     RW   drives button_out
//    BASE_ADDR+3  IRQ_EN  RW   interrupt mask
//    BASE_ADDR+4  FALL    W1C  sticky falling-edge flags (only with
//                              MMIO_FALL_EDGE_EN defined; otherwise this
//                              address is not decoded and goes to RAM)
//    Unused upper bits read as 0.
//
// Optional feature macro: MMIO_FALL_EDGE_EN
//
// Ports:
//    clock         in   system clock, all state updates on the rising edge
//    reset         in   asynchronous active-high reset
//    button_in     in   raw asynchronous button levels [N_BTN-1:0]
//    button_out    out  OUT register contents [N_BTN-1:0]
//    wren          in   processor data write enable
//    address_dmem  in   processor data word address [31:0]
//    data          in   processor write data [31:0]
//    ram_q         in   RAM read data (one-cycle synchronous read) [31:0]
//    ram_wren      out  write enable forwarded to RAM (blocked inside window)
//    q_dmem        out  read data returned to the processor [31:0]
//    irq           out  registered interrupt request
//
// Bus timing: the processor sees read data one cycle after presenting the
// address, same as RAM. A read of a register in the same cycle it is written
// returns the value from before the write.
// -----------------------------------------------------------------------------
module mmio_button_ctrl #(
   parameter int N_BTN           = 4,
   parameter int BASE_ADDR       = 1000,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_BTN-1:0]  button_in,
   output logic [N_BTN-1:0]  button_out,
   input  logic              wren,
   input  logic [31:0]       address_dmem,
   input  logic [31:0]       data,
   input  logic [31:0]       ram_q,
   output logic              ram_wren,
   output logic [31:0]       q_dmem,
   output logic              irq
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef MMIO_FALL_EDGE_EN
   localparam int NREG = 5;
`else
   localparam int NREG = 4;
`endif

   localparam logic [31:0] BASE_W = 32'(BASE_ADDR);
   localparam logic [31:0] NREG_W = 32'(NREG);

   localparam logic [2:0] OFF_STATUS = 3'd0;
   localparam logic [2:0] OFF_EDGE   = 3'd1;
   localparam logic [2:0] OFF_OUT    = 3'd2;
   localparam logic [2:0] OFF_IRQEN  = 3'd3;
`ifdef MMIO_FALL_EDGE_EN
   localparam logic [2:0] OFF_FALL   = 3'd4;
`endif

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [31:0] offset_w;
   logic        hit_w;
   logic        wr_hit_w;

   assign offset_w = address_dmem - BASE_W;
   // The >= test guards against wrap-around of the subtraction below BASE.
   assign hit_w    = (address_dmem >= BASE_W) && (offset_w < NREG_W);
   assign wr_hit_w = wren && hit_w;
   assign ram_wren = wren && !hit_w;

   // Only the low N_BTN bits of write data are stored.
   logic unused_data;
   assign unused_data = ^data;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [N_BTN-1:0] sync1_q, sync2_q;
   logic [N_BTN-1:0] deb_q, deb_d;
   logic [N_BTN-1:0] deb_prev_q;
   logic [CW-1:0]    cnt_q [N_BTN];
   logic [CW-1:0]    cnt_d [N_BTN];
   logic [N_BTN-1:0] edge_q, edge_d;
   logic [N_BTN-1:0] out_q, out_d;
   logic [N_BTN-1:0] irq_en_q, irq_en_d;
   logic             irq_q, irq_d;
   logic             rd_hit_q;
   logic [31:0]      rd_data_q, rd_data_d;
`ifdef MMIO_FALL_EDGE_EN
   logic [N_BTN-1:0] fall_q, fall_d;
`endif

   // ---------------------------------------------------------------------------
   // Debounce: the counter tracks consecutive cycles in which the synchronised
   // level disagrees with the debounced level; any agreeing cycle restarts it.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         deb_d[i] = deb_q[i];
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = ~deb_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Register writes, edge capture and interrupt
   // ---------------------------------------------------------------------------
   logic [N_BTN-1:0] rise_w;
   logic [N_BTN-1:0] edge_clr_w;
   logic [N_BTN-1:0] pend_w;
`ifdef MMIO_FALL_EDGE_EN
   logic [N_BTN-1:0] fall_w;
   logic [N_BTN-1:0] fall_clr_w;
`endif

   // Edges are detected against a delayed copy of the debounced level, so a
   // flag sets the cycle after STATUS changes.
   assign rise_w = deb_q & ~deb_prev_q;

   always_comb begin
      edge_clr_w = '0;
      out_d      = out_q;
      irq_en_d   = irq_en_q;
      if (wr_hit_w) begin
         case (offset_w[2:0])
            OFF_EDGE:  edge_clr_w = data[N_BTN-1:0];
            OFF_OUT:   out_d      = data[N_BTN-1:0];
            OFF_IRQEN: irq_en_d   = data[N_BTN-1:0];
            default:   ;
         endcase
      end
      // Set has priority over a simultaneous write-1-to-clear.
      edge_d = (edge_q & ~edge_clr_w) | rise_w;
   end

`ifdef MMIO_FALL_EDGE_EN
   assign fall_w = ~deb_q & deb_prev_q;

   always_comb begin
      fall_clr_w = '0;
      if (wr_hit_w && (offset_w[2:0] == OFF_FALL)) begin
         fall_clr_w = data[N_BTN-1:0];
      end
      fall_d = (fall_q & ~fall_clr_w) | fall_w;
   end

   assign pend_w = (edge_q | fall_q) & irq_en_q;
`else
   assign pend_w = edge_q & irq_en_q;
`endif

   assign irq_d = |pend_w;

   // ---------------------------------------------------------------------------
   // Read path: register contents are sampled before this cycle's write lands,
   // giving read-before-write behaviour and RAM-matched latency.
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_data_d = '0;
      case (offset_w[2:0])
         OFF_STATUS: rd_data_d[N_BTN-1:0] = deb_q;
         OFF_EDGE:   rd_data_d[N_BTN-1:0] = edge_q;
         OFF_OUT:    rd_data_d[N_BTN-1:0] = out_q;
         OFF_IRQEN:  rd_data_d[N_BTN-1:0] = irq_en_q;
`ifdef MMIO_FALL_EDGE_EN
         OFF_FALL:   rd_data_d[N_BTN-1:0] = fall_q;
`endif
         default:    rd_data_d = '0;
      endcase
   end

   assign q_dmem     = rd_hit_q ? rd_data_q : ram_q;
   assign button_out = out_q;
   assign irq        = irq_q;

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= '0;
         end
         edge_q     <= '0;
         out_q      <= '0;
         irq_en_q   <= '0;
         irq_q      <= 1'b0;
         rd_hit_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         sync1_q    <= button_in;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         edge_q     <= edge_d;
         out_q      <= out_d;
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
         rd_hit_q   <= hit_w;
         rd_data_q  <= rd_data_d;
      end
   end

`ifdef MMIO_FALL_EDGE_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fall_q <= '0;
      end else begin
         fall_q <= fall_d;
      end
   end
`endif

endmodule

// File: tb/tb_mmio_button_ctrl.sv
module tb_mmio_button_ctrl;

  localparam int N_BTN = 4;
  localparam int BASE  = 1000;
  localparam int DEB   = 16;

  logic              clock;
  logic              reset;
  logic [N_BTN-1:0]  button_in;
  logic [N_BTN-1:0]  button_out;
  logic              wren;
  logic [31:0]       address_dmem;
  logic [31:0]       data;
  logic [31:0]       ram_q;
  logic              ram_wren;
  logic [31:0]       q_dmem;
  logic              irq;

  int n_checks;
  int n_errors;

  mmio_button_ctrl #(
    .N_BTN(N_BTN),
    .BASE_ADDR(BASE),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .button_in(button_in),
    .button_out(button_out),
    .wren(wren),
    .address_dmem(address_dmem),
    .data(data),
    .ram_q(ram_q),
    .ram_wren(ram_wren),
    .q_dmem(q_dmem),
    .irq(irq)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // simple synchronous-read RAM behind the block
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ram_q = '0;
  end
  always @(posedge clock) begin
    if (ram_wren) mem[address_dmem[7:0]] <= data;
    ram_q <= mem[address_dmem[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // one-cycle bus read, then compare returned data
  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    wren = 1'b0;
    address_dmem = addr;
    step();
    check(tag, q_dmem, exp);
  endtask

  // one-cycle bus write; checks forwarded write enable before the edge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, input logic exp_ram_wren);
    wren = 1'b1;
    address_dmem = addr;
    data = wdata;
    #1;
    check("ram_wren", {31'd0, ram_wren}, {31'd0, exp_ram_wren});
    step();
    wren = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    button_in = '0;
    wren = 1'b0;
    address_dmem = 32'd0;
    data = 32'd0;
    step(3);
    reset = 1'b0;

    // reset state
    check("rst_button_out", {28'd0, button_out}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_q_dmem", q_dmem, 32'd0);
    for (int a = 0; a < 4; a++) bus_read("rst_reg", BASE + a, 32'd0);

    // RAM pass-through
    bus_write(32'd10, 32'h5, 1'b1);
    bus_read("ram_10", 32'd10, 32'h5);

    // BASE+4 is outside the window in the default build
    bus_write(BASE + 4, 32'h77, 1'b1);
    bus_read("ram_base4", BASE + 4, 32'h77);
    bus_write(BASE - 1, 32'h66, 1'b1);
    bus_read("ram_below", BASE - 1, 32'h66);

    // hold button 1: STATUS changes after 2+DEB edges
    button_in = 4'b0010;
    step(DEB + 1);
    bus_read("status_early", BASE + 0, 32'h0);   // captures level after 17 edges
    bus_read("status_set", BASE + 0, 32'h2);     // captures level after 18 edges
    bus_read("edge_set", BASE + 1, 32'h2);
    check("irq_masked", {31'd0, irq}, 32'd0);

    // short glitch on button 0 is filtered
    button_in = 4'b0011;
    step(10);
    button_in = 4'b0010;
    step(30);
    bus_read("glitch_status", BASE + 0, 32'h2);
    bus_read("glitch_edge", BASE + 1, 32'h2);

    // interrupt enable and W1C
    bus_write(BASE + 3, 32'h2, 1'b0);
    check("irq_lag", {31'd0, irq}, 32'd0);
    step();
    check("irq_on", {31'd0, irq}, 32'd1);
    bus_write(BASE + 1, 32'h2, 1'b0);
    check("irq_lag_clr", {31'd0, irq}, 32'd1);
    step();
    check("irq_off", {31'd0, irq}, 32'd0);
    bus_read("edge_cleared", BASE + 1, 32'h0);

    // release button 1; a falling transition must not set EDGE
    button_in = 4'b0000;
    step(25);
    bus_read("fall_status", BASE + 0, 32'h0);
    bus_read("fall_no_edge", BASE + 1, 32'h0);

    // new rise on bit 1 coincides with a W1C of bit 1: set wins
    button_in = 4'b0010;
    step(DEB + 2);                    // 18 edges: level just went high
    bus_write(BASE + 1, 32'h2, 1'b0); // edge 19: set and clear together
    bus_read("set_wins", BASE + 1, 32'h2);
    check("irq_again", {31'd0, irq}, 32'd1);

    // OUT register, STATUS read-only, read-before-write
    bus_write(BASE + 2, 32'hA, 1'b0);
    check("button_out_a", {28'd0, button_out}, 32'hA);
    bus_read("out_rd", BASE + 2, 32'hA);
    bus_read("irqen_rd", BASE + 3, 32'h2);
    bus_write(BASE + 0, 32'hF, 1'b0);
    bus_read("status_ro", BASE + 0, 32'h2);
    bus_write(BASE + 2, 32'h3, 1'b0);
    check("rbw_old", q_dmem, 32'hA);
    bus_read("rbw_new", BASE + 2, 32'h3);
    bus_write(BASE + 2, 32'hFFFF_FFFF, 1'b0);
    bus_read("upper_zero", BASE + 2, 32'hF);
    check("button_out_f", {28'd0, button_out}, 32'hF);

    // reset mid-debounce
    button_in = 4'b0011;
    step(8);
    reset = 1'b1;
    #1;
    check("async_rst_out", {28'd0, button_out}, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    step(2);
    reset = 1'b0;
    step(DEB + 1);
    bus_read("post_rst_early", BASE + 0, 32'h0);
    bus_read("post_rst_status", BASE + 0, 32'h3);
    bus_read("post_rst_out", BASE + 2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // global timeout so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
